// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared types and defaults for the digital-clock mode/increment sequencer.
//   mode_t      - 2-bit mode encoding: RUN, SET_SEC, SET_MIN, SET_HR
//   DEF_*       - default parameter constants for time_set_controller
//   cnt_width() - bit width of a counter that must hold 0..max_val (minimum 1)
//   next_mode() - mode sequence RUN -> SET_SEC -> SET_MIN -> SET_HR -> RUN
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_SEC = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_HR  = 2'd3
  } mode_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 8;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 400;
  localparam int unsigned DEF_REPEAT_CYCLES     = 100;
  localparam int unsigned DEF_TIMEOUT_CYCLES    = 0;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_RUN:     n = MODE_SET_SEC;
      MODE_SET_SEC: n = MODE_SET_MIN;
      MODE_SET_MIN: n = MODE_SET_HR;
      default:      n = MODE_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// time_set_controller_if: button inputs and datapath-facing outputs of the clock sequencer.
//   inc_btn, mode_btn             - raw active-high push buttons (asynchronous)
//   mode                          - current mode (mode_t)
//   mode_led, run_en              - set-mode indicator, time-advance enable
//   inc_sec, inc_min, inc_hr      - single-cycle increment strobes
// Modports: master (button source / datapath side), slave (the controller).
interface time_set_controller_if;
  import clock_ctrl_pkg::*;

  logic  inc_btn;
  logic  mode_btn;
  mode_t mode;
  logic  mode_led;
  logic  run_en;
  logic  inc_sec;
  logic  inc_min;
  logic  inc_hr;

  modport master (
    output inc_btn, mode_btn,
    input  mode, mode_led, run_en, inc_sec, inc_min, inc_hr
  );

  modport slave (
    input  inc_btn, mode_btn,
    output mode, mode_led, run_en, inc_sec, inc_min, inc_hr
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus debounce counter for one raw push button.
//   clk, rst_n - clock, asynchronous active-low reset
//   raw        - raw asynchronous button level
//   level      - debounced level
//   rise       - one-cycle pulse, registered with the 0->1 change of level
// The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples
// differ from it; any matching sample clears the counter. After reset the path stays
// unarmed until the button has been seen released for DEBOUNCE_CYCLES samples, so a
// button held through reset never produces a press.
module btn_debounce
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [1:0]      vld_q;    // marks when sync_q[1] holds a real sample after reset
  logic            armed_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      vld_q  <= {vld_q[0], 1'b1};
      rise_q <= 1'b0;
      if (vld_q[1]) begin
        if (!armed_q) begin
          // Wait for a confirmed release before any press can be accepted.
          if (sync_q[1]) begin
            cnt_q <= '0;
          end else if (cnt_q == CntLast) begin
            armed_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end else if (sync_q[1] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntLast) begin
          level_q <= sync_q[1];
          rise_q  <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: mode FSM and increment sequencer for the digital clock.
//   clk, rst_n - clock, asynchronous active-low reset
//   io         - time_set_controller_if.slave: raw buttons in; mode, mode_led, run_en and
//                the inc_sec/inc_min/inc_hr strobes out (all registered)
// Both buttons are synchronised and debounced. A mode press steps RUN -> SET_SEC ->
// SET_MIN -> SET_HR -> RUN; an increment press in a set mode strobes the selected field.
// A mode press in the same cycle as an increment press wins and drops the increment.
// TIMEOUT_CYCLES > 0 returns to RUN after that many idle cycles in a set mode.
// Build option: define AUTO_REPEAT_EN for long-press auto-repeat (first repeat after
// LONG_PRESS_CYCLES, then every REPEAT_CYCLES); undefined gives one strobe per press.
module time_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               rst_n,
  time_set_controller_if.slave io
);

  localparam bit          TimeoutEn = TIMEOUT_CYCLES > 0;
  localparam int unsigned IdleW     = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned IdleLastI = TimeoutEn ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleLastI);

  logic inc_level;
  logic inc_press;
  logic unused_mode_level;
  logic mode_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_inc_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (io.inc_btn),
    .level (inc_level),
    .rise  (inc_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_mode_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (io.mode_btn),
    .level (unused_mode_level),
    .rise  (mode_press)
  );

  mode_t            mode_q;
  logic             mode_led_q;
  logic             run_en_q;
  logic             inc_sec_q;
  logic             inc_min_q;
  logic             inc_hr_q;
  logic [IdleW-1:0] idle_cnt_q;

  logic timeout_hit;
  logic fire;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned HoldW = cnt_width(LONG_PRESS_CYCLES);
  localparam int unsigned RepW  = cnt_width(REPEAT_CYCLES);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);

  logic             rep_active_q;
  logic [HoldW-1:0] hold_cnt_q;   // saturates at LONG_PRESS_CYCLES
  logic [RepW-1:0]  rep_cnt_q;    // runs only once hold_cnt_q has saturated
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{LONG_PRESS_CYCLES, REPEAT_CYCLES};
`endif

  always_comb begin
    // Holding the increment button counts as activity, so no timeout while held.
    timeout_hit = TimeoutEn && (mode_q != MODE_RUN) && !inc_press && !inc_level &&
                  (idle_cnt_q == IdleLast);
    fire = 1'b0;
    if (!mode_press && !timeout_hit) begin
      if (inc_press) begin
        fire = (mode_q != MODE_RUN);
      end
`ifdef AUTO_REPEAT_EN
      else if (rep_active_q && inc_level) begin
        fire = (hold_cnt_q == HoldLast) || ((hold_cnt_q == HoldMax) && (rep_cnt_q == RepLast));
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_RUN;
      mode_led_q   <= 1'b0;
      run_en_q     <= 1'b1;
      inc_sec_q    <= 1'b0;
      inc_min_q    <= 1'b0;
      inc_hr_q     <= 1'b0;
      idle_cnt_q   <= '0;
`ifdef AUTO_REPEAT_EN
      rep_active_q <= 1'b0;
      hold_cnt_q   <= '0;
      rep_cnt_q    <= '0;
`endif
    end else begin
      // fire is only ever set in a set mode, so RUN never strobes.
      inc_sec_q <= fire && (mode_q == MODE_SET_SEC);
      inc_min_q <= fire && (mode_q == MODE_SET_MIN);
      inc_hr_q  <= fire && (mode_q == MODE_SET_HR);

      if (mode_press) begin
        mode_q     <= next_mode(mode_q);
        mode_led_q <= (next_mode(mode_q) != MODE_RUN);
        run_en_q   <= (next_mode(mode_q) == MODE_RUN);
        idle_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
        rep_active_q <= 1'b0;
        hold_cnt_q   <= '0;
        rep_cnt_q    <= '0;
`endif
      end else if (timeout_hit) begin
        mode_q     <= MODE_RUN;
        mode_led_q <= 1'b0;
        run_en_q   <= 1'b1;
        idle_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
        rep_active_q <= 1'b0;
        hold_cnt_q   <= '0;
        rep_cnt_q    <= '0;
`endif
      end else begin
        if (!TimeoutEn || (mode_q == MODE_RUN) || inc_press || inc_level) begin
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + IdleW'(1);
        end
`ifdef AUTO_REPEAT_EN
        if (inc_press) begin
          rep_active_q <= (mode_q != MODE_RUN);
          hold_cnt_q   <= '0;
          rep_cnt_q    <= '0;
        end else if (rep_active_q) begin
          if (!inc_level) begin
            rep_active_q <= 1'b0;
            hold_cnt_q   <= '0;
            rep_cnt_q    <= '0;
          end else if (hold_cnt_q != HoldMax) begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end else if (rep_cnt_q == RepLast) begin
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + RepW'(1);
          end
        end
`endif
      end
    end
  end

  assign io.mode     = mode_q;
  assign io.mode_led = mode_led_q;
  assign io.run_en   = run_en_q;
  assign io.inc_sec  = inc_sec_q;
  assign io.inc_min  = inc_min_q;
  assign io.inc_hr   = inc_hr_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller. Stimulus pushes expected output events
// (cycle, mode, strobe vector) into a queue; a negedge monitor pops and compares whenever
// the DUT shows a strobe or a mode change. A second instance with TIMEOUT_CYCLES=50
// covers the inactivity timeout.
module tb_time_set_controller;
  import clock_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  time_set_controller_if bus ();
  time_set_controller_if bus_to ();

  time_set_controller #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20),
    .REPEAT_CYCLES     (5),
    .TIMEOUT_CYCLES    (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  time_set_controller #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20),
    .REPEAT_CYCLES     (5),
    .TIMEOUT_CYCLES    (50)
  ) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus_to)
  );

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [2:0] inc;   // {hr, min, sec}
  } ev_t;

  ev_t exp_q[$];
  logic [1:0] prev_mode = 2'd0;
  logic mon_en = 1'b0;

  function automatic void push(input int c, input logic [1:0] m, input logic [2:0] s);
    ev_t e;
    e.cyc = c;
    e.mode = m;
    e.inc = s;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: every strobe or mode change must match the head of the queue.
  always @(negedge clk) begin : monitor
    logic [2:0] s;
    ev_t e;
    s = {bus.inc_hr, bus.inc_min, bus.inc_sec};
    if (mon_en && (s != 3'b000 || bus.mode != prev_mode)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d mode=%0d inc=%b", cyc, bus.mode, s);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.mode != bus.mode || e.inc != s ||
            bus.mode_led != (e.mode != 2'd0) || bus.run_en != (e.mode == 2'd0)) begin
          bad++;
          $display("FAIL event got cyc=%0d mode=%0d inc=%b led=%b run=%b need cyc=%0d mode=%0d inc=%b",
                   cyc, bus.mode, s, bus.mode_led, bus.run_en, e.cyc, e.mode, e.inc);
        end
      end
    end
    prev_mode <= bus.mode;
  end

  // Raw press of len cycles; the accepted press shows up 7 cycles after the raw rise.
  task automatic tap(input bit is_inc, input int len, input bit ev,
                     input logic [1:0] m, input logic [2:0] s);
    int c0;
    @(posedge clk);
    #1;
    if (is_inc) bus.inc_btn = 1'b1;
    else bus.mode_btn = 1'b1;
    c0 = cyc;
    if (ev) push(c0 + 7, m, s);
    repeat (len) @(posedge clk);
    #1;
    if (is_inc) bus.inc_btn = 1'b0;
    else bus.mode_btn = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int c0;
    int t_in;
    int t_out;
    logic [1:0] cyc_modes [9];
    cyc_modes = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    bus_to.inc_btn = 1'b0;
    bus_to.mode_btn = 1'b0;
    // Reset with both buttons held: no press may come from the held level.
    bus.inc_btn = 1'b1;
    bus.mode_btn = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_mode_led", int'(bus.mode_led), 0);
    chk("rst_run_en", int'(bus.run_en), 1);
    chk("rst_inc", int'({bus.inc_hr, bus.inc_min, bus.inc_sec}), 0);
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.inc_btn = 1'b0;
    bus.mode_btn = 1'b0;
    repeat (20) @(posedge clk);

    // Enter SET_SEC.
    tap(1'b0, 10, 1'b1, 2'd1, 3'b000);

    // Glitches of 1..3 cycles are rejected; a 10-cycle press strobes once.
    for (int g = 1; g <= 3; g++) tap(1'b1, g, 1'b0, 2'd0, 3'b000);
    tap(1'b1, 10, 1'b1, 2'd1, 3'b001);

    // Mode cycling: 2,3,0 then a full 1,2,3,0, then 1,2 to land in SET_MIN.
    for (int i = 0; i < 9; i++) tap(1'b0, 10, 1'b1, cyc_modes[i], 3'b000);

    // Long press in SET_MIN, raw held 40 cycles.
    @(posedge clk);
    #1 bus.inc_btn = 1'b1;
    c0 = cyc;
    push(c0 + 7, 2'd2, 3'b010);
`ifdef AUTO_REPEAT_EN
    push(c0 + 27, 2'd2, 3'b010);
    push(c0 + 32, 2'd2, 3'b010);
    push(c0 + 37, 2'd2, 3'b010);
    push(c0 + 42, 2'd2, 3'b010);
`endif
    repeat (40) @(posedge clk);
    #1 bus.inc_btn = 1'b0;
    repeat (40) @(posedge clk);

    // SET_HR, then both buttons together: mode wins, no inc_hr, no repeat.
    tap(1'b0, 10, 1'b1, 2'd3, 3'b000);
    @(posedge clk);
    #1;
    bus.inc_btn = 1'b1;
    bus.mode_btn = 1'b1;
    c0 = cyc;
    push(c0 + 7, 2'd0, 3'b000);
    repeat (10) @(posedge clk);
    #1 bus.mode_btn = 1'b0;
    repeat (50) @(posedge clk);
    #1 bus.inc_btn = 1'b0;
    repeat (15) @(posedge clk);

    // SET_SEC, 100-cycle hold.
    tap(1'b0, 10, 1'b1, 2'd1, 3'b000);
    @(posedge clk);
    #1 bus.inc_btn = 1'b1;
    c0 = cyc;
    push(c0 + 7, 2'd1, 3'b001);
`ifdef AUTO_REPEAT_EN
    for (int k = 0; k < 16; k++) push(c0 + 27 + 5 * k, 2'd1, 3'b001);
`endif
    repeat (100) @(posedge clk);
    #1 bus.inc_btn = 1'b0;
    repeat (20) @(posedge clk);

    // Timeout instance: enter SET_SEC and stay idle.
    t_in = -1;
    t_out = -1;
    @(posedge clk);
    #1 bus_to.mode_btn = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 10) bus_to.mode_btn = 1'b0;
      if (bus_to.mode == MODE_SET_SEC && t_in < 0) t_in = cyc;
      if (bus_to.mode == MODE_RUN && t_in >= 0 && t_out < 0) t_out = cyc;
    end
    chk("timeout_enter", t_in, c0 + 7);
    chk("timeout_exit", t_out, c0 + 57);
    chk("timeout_run_en", int'(bus_to.run_en), 1);

    repeat (10) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
